uart_receiver_cfg: RTL and testbench
====================================

Name: uart_receiver_cfg

Overview:
- Parametrised successor to the fixed 8N1 comm UART receiver in the miner's comm clock domain.
- Decodes configurable frames: 5–9 data bits, optional odd/even parity, 1 or 2 stop bits.
- Reports parity, framing and break conditions alongside each received word.
- Feeds the command parser; includes its own metastability/majority-vote front end.

Parameters:
comm_clk_frequency, 75000000, comm clock in Hz
baud_rate, 115200, line rate in baud
data_bits, 8, data bits per frame; legal 5..9
parity_mode, 0, 0 = none, 1 = odd, 2 = even
stop_bits, 1, stop bits per frame; legal 1..2

Ports:
clk  in  1  comm clock
rst_n  in  1  reset; active-low, asynchronous
uart_rx  in  1  raw serial input; idle high
tx_new_byte  out  1  one-cycle strobe: word complete
tx_byte  out  data_bits  received word, LSB = first bit on line
tx_parity_err  out  1  pulse with tx_new_byte when parity mismatches
tx_frame_err  out  1  pulse with tx_new_byte when any stop bit samples 0
tx_break  out  1  one-cycle pulse on break detection

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; tx_byte 0.
  - Sync flops, vote samples, filtered rx and old_rx = 1.
  - FSM = IDLE; baud counter = 0.
- Front end:
  - 2-flop synchroniser, then 3-sample majority vote.
  - Filtered rx lags uart_rx by 4 clk.
- Timing:
  - baud_delay = comm_clk_frequency/baud_rate − 1 (16-bit).
  - half = baud_delay>>1.
  - Counter wraps baud_delay→0.
  - Bit sampled when counter == half, i.e. every baud_delay+1 cycles.
- FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on old_rx=1 and rx=0, counter := 0 → START.
  - START: at sample, rx=1 → IDLE (false start, no outputs); rx=0 → DATA, bit index := 0.
  - DATA: shift rx into the MSB of the data_bits shift register (so the first bit ends at bit 0).
    - After data_bits samples → PARITY if parity_mode≠0, else STOP.
  - PARITY: sample one bit.
    - Expected value = XOR of data bits, inverted for odd.
    - Mismatch latches the parity error → STOP.
  - STOP: sample stop_bits bits; any 0 latches the frame error.
    - At the final stop sample, for a break frame (see below): pulse tx_break → BREAK.
    - Otherwise, next cycle:
      - tx_new_byte = 1 for exactly one cycle.
      - tx_byte := data, held until the next strobe.
      - tx_parity_err / tx_frame_err pulse with the strobe.
      - FSM → IDLE.
  - Break frame = all data bits 0, parity bit (if any) 0, and any stop bit 0.
    - No tx_new_byte is issued for a break frame.
  - BREAK: wait for rx=1 → IDLE; falling edges are ignored until then.
- Back-to-back frames:
  - IDLE is entered right after the last stop sample, which is mid-bit.
  - A start edge arriving ≥ half cycles later is accepted; no idle gap is required.
- Error flags:
  - Meaningful only while tx_new_byte = 1.
  - Internal error latches clear on entry to START.
- Reset mid-frame: immediate return to IDLE; no strobe; partial data discarded.
- Strobe latency: tx_new_byte asserts 1 clk after the final stop-bit sample.
- Illegal parameters: data_bits outside 5..9, parity_mode > 2 or stop_bits outside 1..2 → elaboration error via generate check.

Test Plan:
- Defaults (baud_delay 650, half 325), send 0xA5 8N1 at 651 cycles/bit → one tx_new_byte, tx_byte=0xA5, both error flags 0, strobe 1 clk after stop sample.
- Low pulse of 200 cycles on idle line → false start: FSM returns to IDLE, no strobe; a following valid 0x3C frame is received correctly.
- parity_mode=2, send 0x07 with parity bit 0 → tx_byte=0x07, tx_parity_err=1; resend with parity 1 → tx_parity_err=0.
- data_bits=7, stop_bits=2, send 0x55 with second stop bit 0 → tx_byte=0x55, tx_frame_err=1; 0x12 immediately after is decoded cleanly.
- Hold line low for 20 bit times → single tx_break pulse, no tx_new_byte; line high then 0x81 → tx_byte=0x81.
- Assert rst_n low mid-DATA of 0xFF → outputs 0 immediately, no strobe; next frame 0x5A received correctly; single-clk glitches on uart_rx are ignored.

Source files
------------

// File: rtl/uart_receiver_cfg.sv
// Configurable UART receiver for the comm clock domain: 5-9 data bits, optional parity,
// 1-2 stop bits, with synchroniser/majority-vote front end and parity/frame/break reporting.
module uart_receiver_cfg #(
    parameter int comm_clk_frequency = 75000000,
    parameter int baud_rate          = 115200,
    parameter int data_bits          = 8,
    parameter int parity_mode        = 0,
    parameter int stop_bits          = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic                 tx_new_byte,
    output logic [data_bits-1:0] tx_byte,
    output logic                 tx_parity_err,
    output logic                 tx_frame_err,
    output logic                 tx_break
);

    localparam int          DelayInt   = comm_clk_frequency / baud_rate - 1;
    localparam logic [15:0] BaudDelay  = 16'(DelayInt);
    localparam logic [15:0] HalfDelay  = BaudDelay >> 1;
    localparam logic [3:0]  LastBit    = 4'(data_bits - 1);
    localparam logic        LastStop   = (stop_bits == 2);

    if (data_bits < 5 || data_bits > 9 || parity_mode < 0 || parity_mode > 2 ||
        stop_bits < 1 || stop_bits > 2) begin : g_param_check
        $error("uart_receiver_cfg: illegal data_bits/parity_mode/stop_bits");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [1:0]           vote_q;
    logic                 rx_q, old_rx_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [data_bits-1:0] data_q, data_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 new_q, new_d;
    logic [data_bits-1:0] byte_q, byte_d;
    logic                 out_perr_q, out_perr_d;
    logic                 out_ferr_q, out_ferr_d;
    logic                 brk_q, brk_d;
    logic                 vote, sample, ferr_now, exp_par;

    // Majority over the newest synchronised sample and the two before it
    assign vote     = (sync_q[1] & vote_q[0]) | (sync_q[1] & vote_q[1]) | (vote_q[0] & vote_q[1]);
    assign sample   = (cnt_q == HalfDelay);
    assign ferr_now = ferr_q | ~rx_q;
    assign exp_par  = (^data_q) ^ (parity_mode == 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            vote_q     <= 2'b11;
            rx_q       <= 1'b1;
            old_rx_q   <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            new_q      <= 1'b0;
            byte_q     <= '0;
            out_perr_q <= 1'b0;
            out_ferr_q <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            vote_q     <= {vote_q[0], sync_q[1]};
            rx_q       <= vote;
            old_rx_q   <= rx_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            new_q      <= new_d;
            byte_q     <= byte_d;
            out_perr_q <= out_perr_d;
            out_ferr_q <= out_ferr_d;
            brk_q      <= brk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == BaudDelay) ? 16'd0 : 16'(cnt_q + 16'd1);
        bit_d      = bit_q;
        stop_d     = stop_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        new_d      = 1'b0;
        byte_d     = byte_q;
        out_perr_d = 1'b0;
        out_ferr_d = 1'b0;
        brk_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (old_rx_q && !rx_q) begin
                    cnt_d     = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    par_bit_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (sample) begin
                    bit_d   = '0;
                    state_d = rx_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    data_d = {rx_q, data_q[data_bits-1:1]};
                    bit_d  = 4'(bit_q + 4'd1);
                    if (bit_q == LastBit) begin
                        stop_d  = 1'b0;
                        state_d = (parity_mode != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    par_bit_d = rx_q;
                    if (rx_q != exp_par) perr_d = 1'b1;
                    stop_d    = 1'b0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    ferr_d = ferr_now;
                    if (stop_q == LastStop) begin
                        // Break: all-zero data and parity with a low stop bit
                        if (data_q == '0 && !par_bit_q && ferr_now) begin
                            brk_d   = 1'b1;
                            state_d = BREAK;
                        end else begin
                            new_d      = 1'b1;
                            byte_d     = data_q;
                            out_perr_d = perr_q;
                            out_ferr_d = ferr_now;
                            state_d    = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_new_byte   = new_q;
    assign tx_byte       = byte_q;
    assign tx_parity_err = out_perr_q;
    assign tx_frame_err  = out_ferr_q;
    assign tx_break      = brk_q;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Self-checking bench for uart_receiver_cfg: four instances (default 8N1, fast 8N1,
// fast 8E1, fast 7N2) checked through per-instance scoreboards of expected words.
module tb_uart_receiver_cfg;

    localparam int FastClk = 1843200;

    typedef struct {
        logic [8:0] b;
        logic       p;
        logic       f;
    } exp_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         nd;
        bit         hasPar;
        logic       parVal;
        logic [1:0] stopVal;
        int         nstop;
        int         gap;
        logic [8:0] expByte;
        logic       expPerr;
        logic       expFerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxA = 1'b1, rxB = 1'b1, rxC = 1'b1, rxD = 1'b1;
    logic newA, newB, newC, newD;
    logic [7:0] byteA, byteB, byteC;
    logic [6:0] byteD;
    logic perrA, perrB, perrC, perrD;
    logic ferrA, ferrB, ferrC, ferrD;
    logic brkA, brkB, brkC, brkD;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int startCyc = 0;
    int strobeCycA = -1;
    int brkCntA = 0, brkCntB = 0, brkCntC = 0, brkCntD = 0;
    exp_t qA[$], qB[$], qC[$], qD[$];
    vec_t vecs[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver_cfg dutA (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxA), .tx_new_byte(newA), .tx_byte(byteA),
        .tx_parity_err(perrA), .tx_frame_err(ferrA), .tx_break(brkA));

    uart_receiver_cfg #(.comm_clk_frequency(FastClk)) dutB (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxB), .tx_new_byte(newB), .tx_byte(byteB),
        .tx_parity_err(perrB), .tx_frame_err(ferrB), .tx_break(brkB));

    uart_receiver_cfg #(.comm_clk_frequency(FastClk), .parity_mode(2)) dutC (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxC), .tx_new_byte(newC), .tx_byte(byteC),
        .tx_parity_err(perrC), .tx_frame_err(ferrC), .tx_break(brkC));

    uart_receiver_cfg #(.comm_clk_frequency(FastClk), .data_bits(7), .stop_bits(2)) dutD (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxD), .tx_new_byte(newD), .tx_byte(byteD),
        .tx_parity_err(perrD), .tx_frame_err(ferrD), .tx_break(brkD));

    task automatic checkValue(input string nm, input int got, input int req);
        compared++;
        if (got != req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic checkOutput(input string nm, input exp_t e, input logic [8:0] gb,
                               input logic gp, input logic gf);
        checkValue({nm, " tx_byte"}, int'(gb), int'(e.b));
        checkValue({nm, " tx_parity_err"}, int'(gp), int'(e.p));
        checkValue({nm, " tx_frame_err"}, int'(gf), int'(e.f));
    endtask

    task automatic unexpected(input string nm);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s strobe: got unexpected tx_new_byte, required none", nm);
    endtask

    // Scoreboard monitors: pop an expected word on every strobe
    always @(negedge clk) begin
        if (brkA) brkCntA++;
        if (brkB) brkCntB++;
        if (brkC) brkCntC++;
        if (brkD) brkCntD++;
        if (newA) begin
            strobeCycA = cyc;
            if (qA.size() == 0) unexpected("A");
            else checkOutput("A", qA.pop_front(), {1'b0, byteA}, perrA, ferrA);
        end
        if (newB) begin
            if (qB.size() == 0) unexpected("B");
            else checkOutput("B", qB.pop_front(), {1'b0, byteB}, perrB, ferrB);
        end
        if (newC) begin
            if (qC.size() == 0) unexpected("C");
            else checkOutput("C", qC.pop_front(), {1'b0, byteC}, perrC, ferrC);
        end
        if (newD) begin
            if (qD.size() == 0) unexpected("D");
            else checkOutput("D", qD.pop_front(), {2'b00, byteD}, perrD, ferrD);
        end
    end

    function automatic int periodOf(input int sel);
        return (sel == 0) ? 651 : 16;
    endfunction

    task automatic setLine(input int sel, input logic v);
        case (sel)
            0:       rxA = v;
            1:       rxB = v;
            2:       rxC = v;
            default: rxD = v;
        endcase
    endtask

    task automatic sendBit(input int sel, input logic v, input int p, input bit glitch);
        for (int c = 0; c < p; c++) begin
            @(negedge clk);
            if (c == 0) setLine(sel, v);
            else if (glitch && c == 8) setLine(sel, ~v);
            else if (glitch && c == 9) setLine(sel, v);
        end
    endtask

    task automatic pushExp(input int sel, input logic [8:0] b, input logic p, input logic f);
        exp_t e;
        e.b = b;
        e.p = p;
        e.f = f;
        case (sel)
            0:       qA.push_back(e);
            1:       qB.push_back(e);
            2:       qC.push_back(e);
            default: qD.push_back(e);
        endcase
    endtask

    task automatic applyStimulus(input int sel, input logic [8:0] data, input int nd,
                                 input bit hasPar, input logic parVal,
                                 input logic [1:0] stopVal, input int nstop, input bit glitch);
        int p;
        p = periodOf(sel);
        @(negedge clk);
        setLine(sel, 1'b0);
        startCyc = cyc;
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < nd; i++) sendBit(sel, data[i], p, glitch);
        if (hasPar) sendBit(sel, parVal, p, glitch);
        for (int s = 0; s < nstop; s++) sendBit(sel, stopVal[s], p, 1'b0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, 0,  9'h03C, 1'b0, 1'b0};
        vecs[1]  = '{1, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, 0,  9'h0FF, 1'b0, 1'b0};
        vecs[2]  = '{1, 9'h001, 8, 1'b0, 1'b0, 2'b11, 1, 0,  9'h001, 1'b0, 1'b0};
        vecs[3]  = '{1, 9'h080, 8, 1'b0, 1'b0, 2'b11, 1, 0,  9'h080, 1'b0, 1'b0};
        vecs[4]  = '{2, 9'h007, 8, 1'b1, 1'b0, 2'b11, 1, 0,  9'h007, 1'b1, 1'b0};
        vecs[5]  = '{2, 9'h007, 8, 1'b1, 1'b1, 2'b11, 1, 0,  9'h007, 1'b0, 1'b0};
        vecs[6]  = '{2, 9'h000, 8, 1'b1, 1'b0, 2'b11, 1, 0,  9'h000, 1'b0, 1'b0};
        vecs[7]  = '{2, 9'h0C3, 8, 1'b1, 1'b0, 2'b11, 1, 0,  9'h0C3, 1'b0, 1'b0};
        vecs[8]  = '{2, 9'h001, 8, 1'b1, 1'b1, 2'b00, 1, 16, 9'h001, 1'b0, 1'b1};
        vecs[9]  = '{3, 9'h055, 7, 1'b0, 1'b0, 2'b01, 2, 16, 9'h055, 1'b0, 1'b1};
        vecs[10] = '{3, 9'h012, 7, 1'b0, 1'b0, 2'b11, 2, 0,  9'h012, 1'b0, 1'b0};
        vecs[11] = '{3, 9'h07F, 7, 1'b0, 1'b0, 2'b10, 2, 0,  9'h07F, 1'b0, 1'b1};
        vecs[12] = '{3, 9'h000, 7, 1'b0, 1'b0, 2'b11, 2, 0,  9'h000, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        checkValue("reset A tx_new_byte", int'(newA), 0);
        checkValue("reset A tx_byte", int'(byteA), 0);
        checkValue("reset B tx_break", int'(brkB), 0);
        checkValue("reset C tx_parity_err", int'(perrC), 0);
        checkValue("reset D tx_frame_err", int'(ferrD), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] default 8N1 frame 0xA5 with strobe latency");
        pushExp(0, 9'h0A5, 1'b0, 1'b0);
        applyStimulus(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        checkValue("A strobe latency", strobeCycA - startCyc, 6190);

        $display("[TB] table vectors");
        for (int i = 0; i < 13; i++) begin
            pushExp(vecs[i].sel, vecs[i].expByte, vecs[i].expPerr, vecs[i].expFerr);
            applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].nd, vecs[i].hasPar,
                          vecs[i].parVal, vecs[i].stopVal, vecs[i].nstop, 1'b0);
            if (vecs[i].gap > 0) sendBit(vecs[i].sel, 1'b1, vecs[i].gap, 1'b0);
        end

        $display("[TB] false start then 0x3C");
        @(negedge clk);
        rxB = 1'b0;
        repeat (5) @(negedge clk);
        rxB = 1'b1;
        repeat (40) @(negedge clk);
        pushExp(1, 9'h03C, 1'b0, 1'b0);
        applyStimulus(1, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);

        $display("[TB] break then 0x81");
        @(negedge clk);
        rxB = 1'b0;
        repeat (320) @(negedge clk);
        rxB = 1'b1;
        repeat (32) @(negedge clk);
        checkValue("B break pulses", brkCntB, 1);
        pushExp(1, 9'h081, 1'b0, 1'b0);
        applyStimulus(1, 9'h081, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        repeat (8) @(negedge clk);

        $display("[TB] reset mid-frame, glitches, then 0x5A");
        sendBit(1, 1'b0, 16, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1, 1'b1, 16, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("mid-reset B tx_byte", int'(byteB), 0);
        checkValue("mid-reset B tx_new_byte", int'(newB), 0);
        checkValue("mid-reset B tx_break", int'(brkB), 0);
        rxB = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rxB = 1'b0;
        @(negedge clk);
        rxB = 1'b1;
        repeat (20) @(negedge clk);
        pushExp(1, 9'h05A, 1'b0, 1'b0);
        applyStimulus(1, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1, 1'b1);
        sendBit(1, 1'b1, 16, 1'b0);

        repeat (100) @(negedge clk);
        checkValue("A pending words", qA.size(), 0);
        checkValue("B pending words", qB.size(), 0);
        checkValue("C pending words", qC.size(), 0);
        checkValue("D pending words", qD.size(), 0);
        checkValue("A break pulses", brkCntA, 0);
        checkValue("B break pulses final", brkCntB, 1);
        checkValue("C break pulses", brkCntC, 0);
        checkValue("D break pulses", brkCntD, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
